// File: rtl/waveform_plotter.sv
// Scrolling oscilloscope trace: turns decimated audio samples into pixel writes
// for a 160x120 frame buffer (erase column, draw joining segment, advance).
module waveform_plotter #(
  parameter int unsigned DECIM        = 1024,
  parameter logic [2:0]  TRACE_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        pause,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ERASE   = 2'd1,
    DRAW    = 2'd2,
    ADVANCE = 2'd3
  } state_t;

  localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);
  localparam logic [6:0]  ROW_LAST   = 7'd119;
  localparam logic [6:0]  ROW_MID    = 7'd60;
  localparam logic [7:0]  COL_LAST   = 8'd159;

  state_t      state;
  logic [7:0]  col;
  logic [6:0]  prev_y;
  logic [6:0]  cur_y;
  logic [15:0] decim_cnt;
  logic [6:0]  mapped_y;
  logic [6:0]  lo_y;
  logic [6:0]  hi_y;
  logic signed [15:0] s_in;

  assign s_in = sample_in;

  // Saturate to [-59,+60] so that 60 - s always lands on a visible row.
  always_comb begin
    mapped_y = ROW_MID;
    if (s_in > 16'sd60)
      mapped_y = 7'd0;
    else if (s_in < -16'sd59)
      mapped_y = ROW_LAST;
    else
      mapped_y = 7'(16'sd60 - s_in);
  end

  always_comb begin
    lo_y = (prev_y < cur_y) ? prev_y : cur_y;
    hi_y = (prev_y < cur_y) ? cur_y : prev_y;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // The y output register doubles as the row counter while plotting.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      col       <= 8'd0;
      prev_y    <= ROW_MID;
      cur_y     <= ROW_MID;
      decim_cnt <= 16'd0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'd0;
      plot      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (sample_valid && !pause) begin
            if (decim_cnt == DECIM_LAST) begin
              decim_cnt <= 16'd0;
              cur_y     <= mapped_y;
              state     <= ERASE;
              plot      <= 1'b1;
              x         <= col;
              y         <= 7'd0;
              colour    <= BG_COLOUR;
            end else begin
              decim_cnt <= decim_cnt + 16'd1;
            end
          end
        end
        ERASE: begin
          if (y == ROW_LAST) begin
            state  <= DRAW;
            y      <= lo_y;
            colour <= TRACE_COLOUR;
          end else begin
            y <= y + 7'd1;
          end
        end
        DRAW: begin
          if (y == hi_y) begin
            state <= ADVANCE;
            plot  <= 1'b0;
          end else begin
            y <= y + 7'd1;
          end
        end
        ADVANCE: begin
          plot   <= 1'b0;
          prev_y <= cur_y;
          col    <= (col == COL_LAST) ? 8'd0 : col + 8'd1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/waveform_plotter.md
Name: waveform_plotter

Overview:
- Downstream consumer of the scaled audio sample stream (16-bit signed, already gain-shifted).
- Converts samples into pixel write commands for the 160x120 frame-buffer VGA adapter, giving a scrolling oscilloscope trace.
- For each accepted sample it first erases the current screen column, then draws a vertical segment joining the previous sample's row to the new row, then advances the column.

Parameters:
- DECIM, 1024: accept one of every DECIM valid samples; 1 means accept all. Legal range 1..65535.
- TRACE_COLOUR, 3'b010: 3-bit RGB value used when drawing the trace.
- BG_COLOUR, 3'b000: 3-bit RGB value used when erasing a column.

Ports:
- CLOCK_50 input 1: sole clock, rising edge.
- resetn input 1: asynchronous, active-low reset.
- pause input 1: when high, no new samples are accepted; the current screen contents are frozen.
- sample_in input 16: signed two's-complement audio sample.
- sample_valid input 1: single-cycle strobe qualifying sample_in.
- x output 8: pixel column, 0..159.
- y output 7: pixel row, 0..119.
- colour output 3: pixel colour.
- plot output 1: pixel write enable; x, y and colour are valid in the same cycle.
- busy output 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, even mid-column):
  - Outputs: x=0, y=0, colour=0, plot=0, busy=0.
  - Internal: state=IDLE, col=0, prev_y=60, decim_cnt=0.
- Decimation counter:
  - decim_cnt increments on each sample_valid seen while in IDLE with pause=0.
  - A sample is accepted when decim_cnt==DECIM-1; decim_cnt then returns to 0.
  - Any sample_valid that arrives while busy=1 or pause=1 is dropped and does not change decim_cnt.
- Row mapping, computed in the acceptance cycle and registered as cur_y:
  - s = sample_in saturated to the range [-59,+60].
  - cur_y = 60 - s, so cur_y is always in 0..119.
  - +32767 maps to 0, -32768 maps to 119, 0 maps to 60.
- FSM states: IDLE, ERASE, DRAW, ADVANCE.
  - IDLE: plot=0. On acceptance, register cur_y and go to ERASE with row counter r=0.
  - ERASE: each cycle drives plot=1, x=col, y=r, colour=BG_COLOUR, then r increments. After r=119, go to DRAW with r=min(prev_y,cur_y). ERASE lasts exactly 120 cycles.
  - DRAW: each cycle drives plot=1, x=col, y=r, colour=TRACE_COLOUR, then r increments. After r=max(prev_y,cur_y), go to ADVANCE. DRAW lasts |cur_y-prev_y|+1 cycles, minimum 1.
  - ADVANCE: plot=0. Set prev_y=cur_y; col=col+1, wrapping from 159 to 0. Return to IDLE.
- Latency per accepted sample: 120 + |dy| + 1 + 1 cycles. The best case is 122 cycles; the worst case (|dy|=119) is 241 cycles.
- Outputs are registered; plot is never asserted in IDLE or ADVANCE.
- Simultaneous events:
  - sample_valid arriving in the same cycle the FSM re-enters IDLE from ADVANCE is dropped; acceptance is possible only while the registered state is IDLE.
  - pause rising mid-column does not abort the column; the FSM finishes through ADVANCE and then holds in IDLE.
- Wrap-around: after col=159, the next column is 0; prev_y is carried across the wrap, so the trace is continuous at the screen edge.

Test Plan:
- Reset check: with DECIM=1, assert resetn=0 during DRAW -> plot=0, busy=0 and x=0 in the same cycle without waiting for a clock edge; after release, a sample of 0 erases column 0 and then plots exactly one pixel at (0,60) in TRACE_COLOUR.
- Row mapping: with DECIM=1 and prev_y=60, feed sample_in=+100 -> 120 erase writes to column 0 at rows 0..119 in BG_COLOUR, then 61 draw writes at rows 0..60, then col becomes 1. Next feed -32768 -> the draw covers rows 0..119 (120 writes).
- Decimation: with DECIM=4, feed 8 back-to-back valid samples while in IDLE -> exactly 2 are accepted (the 4th and 8th); col ends at 2.
- Drop during busy: with DECIM=1, give 5 strobes during ERASE -> all ignored; only one column is drawn, and the next sample after busy falls is accepted.
- Pause: raise pause in the middle of ERASE -> the column completes and col increments once; then give 10 valid strobes while paused -> plot stays 0 and col is unchanged.
- Wrap: drive 160 accepted samples of 0 and then one of +60 -> the 161st sample erases column 0 and draws rows 0..60 at x=0.
